// File: rtl/ysyx_23060203_rd_arb_if.sv
// ysyx_23060203_rd_arb_if
// Bundles the AXI-style read channels around the read arbiter:
//   m0_* : IFU read-address / read-data channel
//   m1_* : LSU read-address / read-data channel
//   s_*  : shared downstream slave read-address / read-data channel
// Modports:
//   master : the arbiter's view (it masters the shared slave bus and
//            serves the two upstream masters)
//   slave  : the environment's view (upstream masters plus the slave)
interface ysyx_23060203_rd_arb_if;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_araddr;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rlast;

  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_araddr;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rlast;

  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;

  modport master (
    input  m0_arvalid, m0_araddr, m0_arlen, m0_arsize, m0_rready,
    output m0_arready, m0_rvalid, m0_rdata, m0_rresp, m0_rlast,
    input  m1_arvalid, m1_araddr, m1_arlen, m1_arsize, m1_rready,
    output m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_rlast,
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );

  modport slave (
    output m0_arvalid, m0_araddr, m0_arlen, m0_arsize, m0_rready,
    input  m0_arready, m0_rvalid, m0_rdata, m0_rresp, m0_rlast,
    output m1_arvalid, m1_araddr, m1_arlen, m1_arsize, m1_rready,
    input  m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_rlast,
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast
  );
endinterface

// File: rtl/ysyx_23060203_rd_arb.sv
// ysyx_23060203_rd_arb
// Two-master (m0 = IFU, m1 = LSU) read arbiter in front of one slave, one
// transaction outstanding at a time (IDLE -> AR -> R).
// Parameters:
//   RR   : 0 = fixed priority (m1 wins ties), 1 = round-robin
//   NMAX : maximum number of R beats forwarded per transaction
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : read channels of m0, m1 and the shared slave
//   busy  : high while in AR or R
//   grant : owner of the current transaction (0 = m0, 1 = m1)
module ysyx_23060203_rd_arb #(
  parameter bit          RR   = 1'b0,
  parameter int unsigned NMAX = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_23060203_rd_arb_if.master        bus,
  output logic                          busy,
  output logic                          grant
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  localparam logic [8:0] NMAX_W = 9'(NMAX);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [8:0] cnt_q, cnt_d;

  logic       pick;
  logic [8:0] req_beats;
  logic       g_arvalid, g_rready, fwd_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration and beat-count clamp for a request seen in IDLE.
  always_comb begin
    if (bus.m0_arvalid && bus.m1_arvalid) pick = RR ? ~last_q : 1'b1;
    else                                  pick = bus.m1_arvalid;
    req_beats = (pick ? {1'b0, bus.m1_arlen} : {1'b0, bus.m0_arlen}) + 9'd1;
    if (req_beats > NMAX_W) req_beats = NMAX_W;
  end

  assign g_arvalid = grant_q ? bus.m1_arvalid : bus.m0_arvalid;
  assign g_rready  = grant_q ? bus.m1_rready  : bus.m0_rready;
  // The beat that exhausts a truncated burst is presented as the last one.
  assign fwd_last  = bus.s_rlast | (cnt_q == 9'd1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    bus.s_arvalid  = 1'b0;
    bus.s_araddr   = '0;
    bus.s_arlen    = '0;
    bus.s_arsize   = '0;
    bus.s_rready   = 1'b0;
    bus.m0_arready = 1'b0;
    bus.m1_arready = 1'b0;
    bus.m0_rvalid  = 1'b0;
    bus.m0_rdata   = '0;
    bus.m0_rresp   = '0;
    bus.m0_rlast   = 1'b0;
    bus.m1_rvalid  = 1'b0;
    bus.m1_rdata   = '0;
    bus.m1_rresp   = '0;
    bus.m1_rlast   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Silently drain leftovers of a truncated burst; the reset gate keeps
        // s_rready low while reset is held (state is IDLE then).
        bus.s_rready = bus.s_rvalid & reset;
        if (bus.m0_arvalid || bus.m1_arvalid) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = req_beats;
          state_d = AR;
        end
      end

      AR: begin
        bus.s_rready  = bus.s_rvalid;
        bus.s_arvalid = g_arvalid;
        if (grant_q) begin
          bus.s_araddr   = bus.m1_araddr;
          bus.s_arlen    = bus.m1_arlen;
          bus.s_arsize   = bus.m1_arsize;
          bus.m1_arready = bus.s_arready;
        end else begin
          bus.s_araddr   = bus.m0_araddr;
          bus.s_arlen    = bus.m0_arlen;
          bus.s_arsize   = bus.m0_arsize;
          bus.m0_arready = bus.s_arready;
        end
        if (!g_arvalid)         state_d = IDLE;
        else if (bus.s_arready) state_d = R;
      end

      R: begin
        bus.s_rready = g_rready;
        if (grant_q) begin
          bus.m1_rvalid = bus.s_rvalid;
          bus.m1_rdata  = bus.s_rdata;
          bus.m1_rresp  = bus.s_rresp;
          bus.m1_rlast  = fwd_last;
        end else begin
          bus.m0_rvalid = bus.s_rvalid;
          bus.m0_rdata  = bus.s_rdata;
          bus.m0_rresp  = bus.s_rresp;
          bus.m0_rlast  = fwd_last;
        end
        if (bus.s_rvalid && g_rready) begin
          cnt_d = cnt_q - 9'd1;
          if (fwd_last) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

endmodule

// File: tb/tb_ysyx_23060203_rd_arb.sv
// tb_ysyx_23060203_rd_arb
// Scoreboard bench: stimulus tasks push expected R beats (per master) and
// expected AR transfers; a negedge monitor pops and compares on every
// handshake. Instance A: RR=0, NMAX=4. Instance B: RR=1, NMAX=16.
module tb_ysyx_23060203_rd_arb;

  localparam int NMAX_A = 4;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic        g;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic busy_a, grant_a, busy_b, grant_b;
  logic tog0 = 1'b0, tog1 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  beat_t q0[$];
  beat_t q1[$];
  ar_t   arq[$];
  logic  bq[$];

  ysyx_23060203_rd_arb_if ia();
  ysyx_23060203_rd_arb_if ib();

  ysyx_23060203_rd_arb #(.RR(1'b0), .NMAX(NMAX_A)) u_a (
    .clock(clk), .reset(rst_a), .bus(ia), .busy(busy_a), .grant(grant_a)
  );

  ysyx_23060203_rd_arb #(.RR(1'b1), .NMAX(16)) u_b (
    .clock(clk), .reset(rst_b), .bus(ib), .busy(busy_b), .grant(grant_b)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void exp_ar(input logic g, input logic [31:0] addr,
                                 input logic [7:0] len);
    ar_t a;
    a.g = g; a.addr = addr; a.len = len;
    arq.push_back(a);
  endfunction

  // Master rready drivers: steady high or toggling every cycle.
  always @(posedge clk) begin
    #1;
    ia.m0_rready = tog0 ? ~ia.m0_rready : 1'b1;
    ia.m1_rready = tog1 ? ~ia.m1_rready : 1'b1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (ia.m0_rvalid && ia.m0_rready) begin
      chk("m0_beat_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        beat_t b;
        b = q0.pop_front();
        chk("m0_rdata", ia.m0_rdata, b.data);
        chk("m0_rresp", 32'(ia.m0_rresp), 32'(b.resp));
        chk("m0_rlast", 32'(ia.m0_rlast), 32'(b.last));
      end
    end
    if (ia.m1_rvalid && ia.m1_rready) begin
      chk("m1_beat_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        beat_t b;
        b = q1.pop_front();
        chk("m1_rdata", ia.m1_rdata, b.data);
        chk("m1_rresp", 32'(ia.m1_rresp), 32'(b.resp));
        chk("m1_rlast", 32'(ia.m1_rlast), 32'(b.last));
      end
    end
    if (ia.s_arvalid && ia.s_arready) begin
      chk("s_ar_expected", 32'(arq.size() != 0), 1);
      if (arq.size() != 0) begin
        ar_t a;
        a = arq.pop_front();
        chk("ar_grant", 32'(grant_a), 32'(a.g));
        chk("s_araddr", ia.s_araddr, a.addr);
        chk("s_arlen", 32'(ia.s_arlen), 32'(a.len));
      end
    end
    // Idle with slave data pending: must be drained, never forwarded.
    if (rst_a && !busy_a && ia.s_rvalid) begin
      chk("drain_no_rvalid", 32'({ia.m0_rvalid, ia.m1_rvalid}), 0);
      chk("drain_rready", 32'(ia.s_rready), 1);
    end
    if (ib.s_arvalid && ib.s_arready && bq.size() != 0)
      chk("rr_grant", 32'(grant_b), 32'(bq.pop_front()));
  end

  task automatic issue(input bit m, input logic [31:0] addr, input logic [7:0] len);
    int nb;
    bit got;
    nb = (int'(len) + 1 > NMAX_A) ? NMAX_A : int'(len) + 1;
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.data = addr + 32'(i);
      b.resp = 2'(i);
      b.last = (i == nb - 1);
      if (m) q1.push_back(b); else q0.push_back(b);
    end
    if (m) begin
      ia.m1_arvalid = 1'b1; ia.m1_araddr = addr; ia.m1_arlen = len;
    end else begin
      ia.m0_arvalid = 1'b1; ia.m0_araddr = addr; ia.m0_arlen = len;
    end
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = m ? (ia.m1_arvalid && ia.m1_arready) : (ia.m0_arvalid && ia.m0_arready);
    end
    chk(m ? "m1_ar_accept" : "m0_ar_accept", 32'(got), 1);
    @(posedge clk); #1;
    if (m) ia.m1_arvalid = 1'b0; else ia.m0_arvalid = 1'b0;
  endtask

  task automatic wait_s_ar(output bit got);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = ia.s_arvalid && ia.s_arready;
    end
    chk("slave_ar_seen", 32'(got), 1);
  endtask

  // Slave model: after the next AR handshake, return n beats base+i.
  task automatic serve(input int n, input logic [31:0] base);
    bit got;
    wait_s_ar(got);
    if (!got) return;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ia.s_rvalid = 1'b1;
      ia.s_rdata  = base + 32'(i);
      ia.s_rresp  = 2'(i);
      ia.s_rlast  = (i == n - 1);
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        @(negedge clk);
        got = ia.s_rready;
      end
      if (!got) begin
        chk("slave_beat_accept", 32'(got), 1);
        break;
      end
    end
    @(posedge clk); #1;
    ia.s_rvalid = 1'b0;
    ia.s_rlast  = 1'b0;
  endtask

  // Instance B: both masters request forever, single-beat bursts.
  initial begin
    rst_b = 1'b0;
    ib.m0_arvalid = 1'b1; ib.m0_araddr = 32'h100; ib.m0_arlen = 8'd0; ib.m0_arsize = 3'd2;
    ib.m1_arvalid = 1'b1; ib.m1_araddr = 32'h200; ib.m1_arlen = 8'd0; ib.m1_arsize = 3'd2;
    ib.m0_rready = 1'b1; ib.m1_rready = 1'b1;
    ib.s_arready = 1'b1; ib.s_rvalid = 1'b1; ib.s_rlast = 1'b1;
    ib.s_rdata = 32'h0; ib.s_rresp = 2'b00;
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  end

  initial begin
    bit got;
    rst_a = 1'b0;
    ia.m0_arvalid = 1'b1; ia.m0_araddr = '0; ia.m0_arlen = '0; ia.m0_arsize = 3'd2;
    ia.m1_arvalid = 1'b1; ia.m1_araddr = '0; ia.m1_arlen = '0; ia.m1_arsize = 3'd2;
    ia.m0_rready = 1'b1; ia.m1_rready = 1'b1;
    ia.s_arready = 1'b1; ia.s_rvalid = 1'b1; ia.s_rlast = 1'b0;
    ia.s_rdata = 32'hdead_beef; ia.s_rresp = 2'b00;

    // Reset state with requests and slave data pending.
    #2;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_s_arvalid", 32'(ia.s_arvalid), 0);
    chk("rst_s_rready", 32'(ia.s_rready), 0);
    chk("rst_arready", 32'({ia.m0_arready, ia.m1_arready}), 0);
    chk("rst_rvalid", 32'({ia.m0_rvalid, ia.m1_rvalid}), 0);
    ia.m0_arvalid = 1'b0; ia.m1_arvalid = 1'b0; ia.s_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1;

    // Fixed priority: m1 first, then m0; one-cycle request latency.
    exp_ar(1'b1, 32'h1000, 8'd0);
    exp_ar(1'b0, 32'h2000, 8'd0);
    fork
      issue(1'b0, 32'h2000, 8'd0);
      issue(1'b1, 32'h1000, 8'd0);
      begin serve(1, 32'h1000); serve(1, 32'h2000); end
      begin
        @(negedge clk);
        chk("lat_t_s_arvalid", 32'(ia.s_arvalid), 0);
        @(negedge clk);
        chk("lat_t1_s_arvalid", 32'(ia.s_arvalid), 1);
        chk("lat_t1_grant", 32'(grant_a), 1);
        chk("lat_t1_s_araddr", ia.s_araddr, 32'h1000);
      end
    join

    // m1 burst of 4 with toggling rready.
    @(posedge clk); #1;
    tog1 = 1'b1;
    exp_ar(1'b1, 32'h3000, 8'd3);
    fork
      issue(1'b1, 32'h3000, 8'd3);
      serve(4, 32'h3000);
    join
    tog1 = 1'b0;
    @(negedge clk);
    chk("burst4_idle", 32'(busy_a), 0);
    chk("burst4_all_beats", 32'(q1.size()), 0);

    // Truncation: arlen 7 with NMAX 4; beats 5..8 are drained.
    @(posedge clk); #1;
    exp_ar(1'b0, 32'h4000, 8'd7);
    fork
      issue(1'b0, 32'h4000, 8'd7);
      serve(8, 32'h4000);
    join
    chk("trunc_all_beats", 32'(q0.size()), 0);

    // Request withdrawn in AR while the slave stalls.
    @(posedge clk); #1;
    ia.s_arready = 1'b0;
    ia.m0_arvalid = 1'b1; ia.m0_araddr = 32'h5000; ia.m0_arlen = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_ar_pending", 32'(ia.s_arvalid), 1);
    chk("flush_busy_in_ar", 32'(busy_a), 1);
    @(posedge clk); #1;
    ia.m0_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_s_arvalid", 32'(ia.s_arvalid), 0);
    chk("flush_idle", 32'(busy_a), 0);
    @(posedge clk); #1;
    ia.s_arready = 1'b1;

    // Reset mid-burst after one of four beats.
    exp_ar(1'b1, 32'h6000, 8'd3);
    fork
      issue(1'b1, 32'h6000, 8'd3);
      begin
        wait_s_ar(got);
        @(posedge clk); #1;
        ia.s_rvalid = 1'b1; ia.s_rdata = 32'h6000; ia.s_rresp = 2'd0; ia.s_rlast = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        ia.s_rdata = 32'h6001; ia.s_rresp = 2'd1;
        #3 rst_a = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_s_arvalid", 32'(ia.s_arvalid), 0);
        chk("midrst_s_rready", 32'(ia.s_rready), 0);
        chk("midrst_rvalid", 32'({ia.m0_rvalid, ia.m1_rvalid}), 0);
        chk("midrst_grant", 32'(grant_a), 0);
        q1.delete();
        @(posedge clk); #1;
        rst_a = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("postrst_m1_rvalid", 32'(ia.m1_rvalid), 0);
        end
        @(posedge clk); #1;
        ia.s_rvalid = 1'b0;
      end
    join

    // New grant after reset works normally.
    @(posedge clk); #1;
    exp_ar(1'b0, 32'h7000, 8'd1);
    fork
      issue(1'b0, 32'h7000, 8'd1);
      serve(2, 32'h7000);
    join

    repeat (4) @(posedge clk);
    chk("end_q0_empty", 32'(q0.size()), 0);
    chk("end_q1_empty", 32'(q1.size()), 0);
    chk("end_ar_empty", 32'(arq.size()), 0);
    chk("end_rr_seq_done", 32'(bq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_rd_arb.md
YSYX_23060203_RD_ARB -- requirements
Module: ysyx_23060203_rd_arb

Interface
REQ-001 Parameter RR, default 0: 0 = fixed priority (m1/LSU wins ties); 1 = round-robin (the master not granted last wins ties).
REQ-002 Parameter NMAX, default 16: maximum R beats per transaction (arlen+1); a larger request is truncated per REQ-019.
REQ-003 Reset is asynchronous and active-low; the design uses one clock.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 m0_arvalid / m1_arvalid  in  1  read-address request from m0 (IFU) / m1 (LSU).
REQ-007 m0_arready / m1_arready  out  1  read-address accept to m0 / m1.
REQ-008 mN_araddr / mN_arlen / mN_arsize  in  32/8/3  AR payload of master N.
REQ-009 mN_rvalid  out  1  read-data valid to master N.
REQ-010 mN_rready  in  1  read-data ready from master N.
REQ-011 mN_rdata / mN_rresp / mN_rlast  out  32/2/1  R payload to master N.
REQ-012 s_arvalid / s_arready  out/in  1  AR handshake to/from the shared slave.
REQ-013 s_araddr / s_arlen / s_arsize  out  32/8/3  AR payload to the slave.
REQ-014 s_rvalid / s_rready  in/out  1  R handshake from/to the slave.
REQ-015 s_rdata / s_rresp / s_rlast  in  32/2/1  R payload from the slave.
REQ-016 busy  out  1  high in AR and R states.
REQ-017 grant  out  1  owner of the current transaction (0 = m0, 1 = m1); valid while busy.

Function
REQ-018 FSM states: IDLE, AR, R; at most one outstanding transaction.
REQ-019 IDLE: any mN_arvalid → register grant per REQ-001, update last-grant, latch beat count min(arlen+1, NMAX), → AR next cycle; no request → stay.
REQ-020 AR: s_ar* = granted master's ar* (combinational mux on the registered grant); s_arvalid = granted arvalid; granted arready = s_arready; on s_arvalid & s_arready → R.
REQ-021 R: granted mN_rvalid = s_rvalid; s_rready = granted mN_rready; r payload forwarded unmodified; each s_rvalid & s_rready handshake decrements the beat counter.
REQ-022 R exit: a handshake with s_rlast = 1 or beat counter = 1 → IDLE; the forwarded rlast is forced to 1 on that beat.
REQ-023 Beats arriving after a truncated transaction ends (IDLE/AR) are accepted: s_rready = 1 in IDLE only if s_rvalid is high, data is dropped, and no mN_rvalid is asserted.
REQ-024 Non-granted master: arready = 0 and rvalid = 0 at all times; its ar payload never reaches the slave.
REQ-025 Latency: request in IDLE at cycle t → s_arvalid at t+1; last R handshake at cycle u → new grant decision at u+1 and s_arvalid at u+2.
REQ-026 A granted master that drops arvalid in AR before the handshake (e.g. flush) → return to IDLE next cycle with no slave transaction.
REQ-027 Both masters requesting continuously with RR=1 → grants strictly alternate.
REQ-028 When not forwarding, mN_rdata/rresp/rlast = 0.

Reset
REQ-029 reset low → immediately, asynchronously: state = IDLE, grant = 0, last-grant = 0 (m0 treated as last), beat counter = 0, busy = 0.
REQ-030 During reset: s_arvalid = s_rready = 0; m0/m1 arready = rvalid = 0.
REQ-031 Reset asserted mid-transaction abandons it; no R beat is forwarded after reset release until a new grant.

Verification
REQ-032 RR=0: m0 and m1 both request at cycle 0 → grant = 1 at cycle 1; m1's araddr on s_araddr; m0 served after m1's rlast.
REQ-033 RR=1: both request continuously for 4 transactions of arlen = 0 → grant sequence 1,0,1,0 (last-grant resets to m0).
REQ-034 m1 arlen = 3, slave returns 4 beats with rready toggling → exactly 4 m1_rvalid & m1_rready handshakes, rlast on the 4th, then IDLE.
REQ-035 NMAX = 4, arlen = 7, slave returns 8 beats → 4 beats forwarded (the 4th with rlast = 1), 4 beats drained silently, and m0 and m1 see no rvalid during the drain.
REQ-036 Reset pulled low in R after 1 of 4 beats → busy = 0 and all valids = 0 in the same cycle; no m-side rvalid after release until a new AR.
REQ-037 m0 drops arvalid in AR while s_arready = 0 → s_arvalid = 0 next cycle, state = IDLE, and the slave sees no handshake.
